// File: rtl/image_mem_responder.sv
// image_mem_responder: template/window pixel store served to the NCC initiator, with a write log.
// Define RESP_BOUNDS_CHECK_EN to flag and drop accesses whose row or col is >= IMG_DIM.
module image_mem_responder #(
    parameter int ADDR_W    = 7,
    parameter int IMG_DIM   = 128,
    parameter int DATA_W    = 32,
    parameter int LOG_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic              load_tem_win,
    input  logic [ADDR_W-1:0] load_row,
    input  logic [ADDR_W-1:0] load_col,
    input  logic [7:0]        load_data,
    input  logic              load_done,
    input  logic              restart,
    input  logic              req,
    input  logic              rd_wr,
    input  logic [ADDR_W-1:0] row,
    input  logic [ADDR_W-1:0] col,
    input  logic              tem_win,
    input  logic [DATA_W-1:0] write_data,
    input  logic              set_done,
    output logic [DATA_W-1:0] read_data,
    output logic              rd_valid,
    output logic              ready_2_start,
    input  logic              log_rd,
    output logic [DATA_W-1:0] log_data,
    output logic              log_empty,
    output logic              log_ovf,
    output logic              addr_err
);
    localparam int MEM_SZ = 1 << (2 * ADDR_W);
    localparam int LOG_AW = $clog2(LOG_DEPTH);
    localparam logic [LOG_AW:0] FULL_CNT = (LOG_AW + 1)'(LOG_DEPTH);

    typedef enum logic [1:0] {IDLE, READY, DONE} state_t;
    state_t state;

    logic [7:0]          tem_mem [MEM_SZ];
    logic [7:0]          win_mem [MEM_SZ];
    logic [DATA_W-1:0]   log_mem [LOG_DEPTH];
    logic [LOG_AW-1:0]   wr_ptr;
    logic [LOG_AW-1:0]   rd_ptr;
    logic [LOG_AW:0]     count;
    logic [2*ADDR_W-1:0] ld_addr;
    logic [2*ADDR_W-1:0] rd_addr;
    logic [7:0]          pixel;
    logic ld_oob, rq_oob;
    logic ld_en, rd_en, wr_en;
    logic push, pop, full, empty;

`ifdef RESP_BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] DIM = (ADDR_W + 1)'(IMG_DIM);
    assign ld_oob = ({1'b0, load_row} >= DIM) || ({1'b0, load_col} >= DIM);
    assign rq_oob = ({1'b0, row} >= DIM) || ({1'b0, col} >= DIM);
`else
    localparam int unused_dim = IMG_DIM;
    assign ld_oob = 1'b0;
    assign rq_oob = 1'b0;
`endif

    assign ld_addr = {load_row, load_col};
    assign rd_addr = {row, col};
    assign pixel   = tem_win ? win_mem[rd_addr] : tem_mem[rd_addr];

    assign ld_en = (state == IDLE) && load_valid && !ld_oob;
    assign rd_en = (state == READY) && req && rd_wr;
    assign wr_en = (state == READY) && req && !rd_wr && !rq_oob;

    // A pop in the same cycle frees a slot, so a push into a full log still lands.
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign pop   = log_rd && !empty;
    assign push  = wr_en && (!full || pop);

    assign log_empty = empty;
    assign log_data  = empty ? '0 : log_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (ld_en) begin
            if (load_tem_win)
                win_mem[ld_addr] <= load_data;
            else
                tem_mem[ld_addr] <= load_data;
        end
        if (push)
            log_mem[wr_ptr] <= write_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            read_data     <= '0;
            rd_valid      <= 1'b0;
            ready_2_start <= 1'b0;
            addr_err      <= 1'b0;
            log_ovf       <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    addr_err <= load_valid && ld_oob;
                    if (load_done) begin
                        state         <= READY;
                        ready_2_start <= 1'b1;
                    end
                end
                READY: begin
                    addr_err <= req && rq_oob;
                    if (rd_en) begin
                        rd_valid  <= 1'b1;
                        read_data <= rq_oob ? '0 : {{(DATA_W-8){1'b0}}, pixel};
                    end
                    if (set_done) begin
                        state         <= DONE;
                        ready_2_start <= 1'b0;
                    end
                end
                DONE: begin
                    read_data <= '0;
                    if (restart)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (pop)
                rd_ptr <= rd_ptr + LOG_AW'(1);
            if (push)
                wr_ptr <= wr_ptr + LOG_AW'(1);
            if (push && !pop)
                count <= count + (LOG_AW + 1)'(1);
            else if (pop && !push)
                count <= count - (LOG_AW + 1)'(1);
            if (wr_en && full && !pop)
                log_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_image_mem_responder.sv
// Bench for image_mem_responder: directed + random steps against an array/queue reference model.
// Build with RESP_BOUNDS_CHECK_EN defined to exercise the bounds-checking variant.
module tb_image_mem_responder;
    localparam int ADDR_W    = 7;
    localparam int IMG_DIM   = 100;
    localparam int DATA_W    = 32;
    localparam int LOG_DEPTH = 16;
`ifdef RESP_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              load_valid, load_tem_win, load_done, restart;
    logic [ADDR_W-1:0] load_row, load_col;
    logic [7:0]        load_data;
    logic              req, rd_wr, tem_win, set_done, log_rd;
    logic [ADDR_W-1:0] row, col;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data, log_data;
    logic              rd_valid, ready_2_start, log_empty, log_ovf, addr_err;

    image_mem_responder #(
        .ADDR_W(ADDR_W), .IMG_DIM(IMG_DIM), .DATA_W(DATA_W), .LOG_DEPTH(LOG_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_tem_win(load_tem_win),
        .load_row(load_row), .load_col(load_col), .load_data(load_data),
        .load_done(load_done), .restart(restart),
        .req(req), .rd_wr(rd_wr), .row(row), .col(col), .tem_win(tem_win),
        .write_data(write_data), .set_done(set_done),
        .read_data(read_data), .rd_valid(rd_valid), .ready_2_start(ready_2_start),
        .log_rd(log_rd), .log_data(log_data), .log_empty(log_empty),
        .log_ovf(log_ovf), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Reference model: 0=idle, 1=ready, 2=done.
    logic [7:0]          m_tem [1 << (2*ADDR_W)];
    logic [7:0]          m_win [1 << (2*ADDR_W)];
    logic [DATA_W-1:0]   m_log [$];
    logic [2*ADDR_W:0]   ld_list [$];
    int                  m_state;
    logic [DATA_W-1:0]   e_data;
    logic                e_valid, e_aerr, e_ovf;
    int                  vectors, errors;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit oob(input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] c);
        return BOUNDS && ((int'(r) >= IMG_DIM) || (int'(c) >= IMG_DIM));
    endfunction

    task automatic check_outputs();
        check("read_data", read_data, e_data);
        check("rd_valid", {31'b0, rd_valid}, {31'b0, e_valid});
        check("ready_2_start", {31'b0, ready_2_start}, (m_state == 1) ? 32'd1 : 32'd0);
        check("log_empty", {31'b0, log_empty}, (m_log.size() == 0) ? 32'd1 : 32'd0);
        check("log_data", log_data, (m_log.size() > 0) ? m_log[0] : 32'd0);
        check("log_ovf", {31'b0, log_ovf}, {31'b0, e_ovf});
        check("addr_err", {31'b0, addr_err}, {31'b0, e_aerr});
    endtask

    task automatic clear_strobes();
        load_valid = 0; load_done = 0; restart = 0;
        req = 0; set_done = 0; log_rd = 0;
    endtask

    task automatic tick();
        bit push;
        int ns;
        push    = 0;
        e_valid = 0;
        e_aerr  = 0;
        ns      = m_state;
        if (m_state == 0) begin
            if (load_valid) begin
                if (oob(load_row, load_col))
                    e_aerr = 1;
                else if (load_tem_win)
                    m_win[{load_row, load_col}] = load_data;
                else
                    m_tem[{load_row, load_col}] = load_data;
            end
            if (load_done) ns = 1;
        end else if (m_state == 1) begin
            if (req) begin
                e_aerr = oob(row, col);
                if (rd_wr) begin
                    e_valid = 1;
                    if (oob(row, col))
                        e_data = 0;
                    else
                        e_data = {24'b0, tem_win ? m_win[{row, col}] : m_tem[{row, col}]};
                end else if (!oob(row, col)) begin
                    push = 1;
                end
            end
            if (set_done) ns = 2;
        end else begin
            e_data = 0;
            if (restart) ns = 0;
        end
        if (log_rd && m_log.size() > 0)
            void'(m_log.pop_front());
        if (push) begin
            if (m_log.size() < LOG_DEPTH) m_log.push_back(write_data);
            else e_ovf = 1;
        end
        m_state = ns;
        @(posedge clk);
        #1;
        check_outputs();
        clear_strobes();
    endtask

    task automatic apply_reset();
        rst = 1;
        #2;
        m_state = 0; e_data = 0; e_valid = 0; e_aerr = 0; e_ovf = 0;
        m_log.delete();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        clear_strobes();
        rst = 0;
    endtask

    task automatic set_load(input bit tw, input int r, input int c, input logic [7:0] d);
        load_valid   = 1;
        load_tem_win = tw;
        load_row     = ADDR_W'(r);
        load_col     = ADDR_W'(c);
        load_data    = d;
        ld_list.push_back({tw, ADDR_W'(r), ADDR_W'(c)});
    endtask

    task automatic set_rd(input bit tw, input int r, input int c);
        req = 1; rd_wr = 1; tem_win = tw;
        row = ADDR_W'(r); col = ADDR_W'(c);
    endtask

    task automatic set_wr(input logic [DATA_W-1:0] d, input int r);
        req = 1; rd_wr = 0; write_data = d;
        row = ADDR_W'(r); col = '0;
    endtask

    initial begin
        logic [2*ADDR_W:0] a;
        vectors = 0; errors = 0;
        clear_strobes();
        rst = 1; load_tem_win = 0; load_row = '0; load_col = '0; load_data = '0;
        rd_wr = 1; tem_win = 0; row = '0; col = '0; write_data = '0;
        #1;
        apply_reset();

        set_load(0, 3, 5, 8'h2A);     tick();
        set_load(1, 0, 0, 8'h11);     tick();
        set_load(1, 127, 127, 8'hFF); tick();
        set_load(0, 1, 1, 8'h3C);     tick();
        set_load(1, 100, 0, 8'h77);   tick();
        for (int i = 0; i < 40; i++) begin
            set_load($urandom_range(0, 1) == 1, 6 + $urandom_range(0, 121),
                     $urandom_range(0, 127), 8'($urandom));
            tick();
        end
        set_load(0, 2, 2, 8'h5A);
        load_done = 1;
        tick();

        set_rd(0, 3, 5); tick();
        tick();
        set_rd(1, 0, 0); tick();
        set_rd(1, 127, 127); tick();
        set_rd(1, 100, 0); tick();

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: ;
                1, 2: begin
                    a = ld_list[$urandom_range(0, ld_list.size() - 1)];
                    set_rd(a[2*ADDR_W], int'(a[2*ADDR_W-1:ADDR_W]), int'(a[ADDR_W-1:0]));
                end
                default: begin
                    load_valid = 1; load_tem_win = 0;
                    load_row = 3; load_col = 5; load_data = 8'($urandom);
                end
            endcase
            tick();
        end
        set_rd(0, 3, 5); tick();

        for (int i = 0; i <= 16; i++) begin
            set_wr(DATA_W'(i), 0);
            tick();
        end
        for (int i = 0; i <= 16; i++) begin
            log_rd = 1;
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            set_wr(DATA_W'(100 + i), 0);
            tick();
        end
        set_wr(32'd200, 0); log_rd = 1; tick();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) set_wr($urandom, $urandom_range(0, 127));
            log_rd = ($urandom_range(0, 2) == 0);
            tick();
        end

        set_rd(0, 1, 1); set_done = 1; tick();
        set_rd(0, 3, 5); tick();
        log_rd = 1; tick();
        set_wr(32'hDEAD, 0); tick();
        restart = 1; tick();
        set_load(0, 120, 3, 8'h99); tick();
        load_done = 1; tick();
        set_rd(0, 120, 3); tick();
        set_rd(0, 3, 5); tick();

        set_rd(0, 1, 1);
        apply_reset();
        tick();
        load_done = 1; tick();
        set_rd(0, 3, 5); tick();
        set_rd(1, 100, 0); tick();
        set_rd(0, 1, 1); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
